// File: rtl/seq_mul_result_acc.sv
// Accumulates BATCH multiplier products into a saturating sum held in a one-entry valid/ready slot.
// Sum is valid the cycle after the final product strobe; a batch completing into a full slot is dropped and flags overrun.
module seq_mul_result_acc #(
    parameter int ACC_W = 16,
    parameter int BATCH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       prod_in,
    input  logic             prod_done,
    input  logic             clear,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             sum_sat,
    output logic [CNT_W-1:0] count,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             batch_sat_q, batch_sat_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sum_vld_q, sum_vld_d;
    logic             sum_sat_q, sum_sat_d;
    logic             overrun_q, overrun_d;

    logic [ACC_W:0]   add_sum;
    logic             add_carry;
    logic [ACC_W-1:0] add_res;
    logic             res_sat;
    logic             take;
    logic             last;
    logic             accept;
    logic             slot_free;

    // One extra bit catches the carry; a saturated batch stays pinned at ACC_MAX.
    always_comb begin
        add_sum   = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod_in};
        add_carry = add_sum[ACC_W];
        add_res   = add_carry ? ACC_MAX : add_sum[ACC_W-1:0];
        res_sat   = batch_sat_q | add_carry;
        take      = prod_done & ~clear;
        last      = take & (cnt_q == LAST_CNT);
        accept    = sum_vld_q & sum_ready;
        slot_free = ~sum_vld_q | sum_ready;
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        batch_sat_d = batch_sat_q;
        sum_d       = sum_q;
        sum_vld_d   = sum_vld_q;
        sum_sat_d   = sum_sat_q;
        overrun_d   = overrun_q;

        if (clear || last) begin
            acc_d       = '0;
            cnt_d       = '0;
            batch_sat_d = 1'b0;
        end else if (take) begin
            acc_d       = add_res;
            cnt_d       = cnt_q + CNT_ONE;
            batch_sat_d = res_sat;
        end

        if (accept) begin
            sum_vld_d = 1'b0;
        end

        // A load into a slot being drained this cycle wins over the drain.
        if (last) begin
            if (slot_free) begin
                sum_d     = add_res;
                sum_sat_d = res_sat;
                sum_vld_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            batch_sat_q <= 1'b0;
            sum_q       <= '0;
            sum_vld_q   <= 1'b0;
            sum_sat_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            batch_sat_q <= batch_sat_d;
            sum_q       <= sum_d;
            sum_vld_q   <= sum_vld_d;
            sum_sat_q   <= sum_sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = sum_vld_q;
    assign sum_sat   = sum_sat_q;
    assign count     = cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seq_mul_result_acc.sv
// Drives three accumulator configurations (16b/4, 8b/4, 16b/2) from shared inputs against a behavioural model.
module tb_seq_mul_result_acc;

    logic       clk;
    logic       reset;
    logic [7:0] prod_in;
    logic       prod_done;
    logic       clear;
    logic       sum_ready;

    logic [15:0] sum_out_a;
    logic        sum_valid_a, sum_sat_a, overrun_a;
    logic [7:0]  count_a;
    logic [7:0]  sum_out_b;
    logic        sum_valid_b, sum_sat_b, overrun_b;
    logic [7:0]  count_b;
    logic [15:0] sum_out_c;
    logic        sum_valid_c, sum_sat_c, overrun_c;
    logic [7:0]  count_c;

    int total = 0;
    int bad   = 0;

    seq_mul_result_acc #(.ACC_W(16), .BATCH(4), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .prod_in(prod_in), .prod_done(prod_done), .clear(clear),
        .sum_out(sum_out_a), .sum_valid(sum_valid_a), .sum_ready(sum_ready),
        .sum_sat(sum_sat_a), .count(count_a), .overrun(overrun_a));

    seq_mul_result_acc #(.ACC_W(8), .BATCH(4), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .prod_in(prod_in), .prod_done(prod_done), .clear(clear),
        .sum_out(sum_out_b), .sum_valid(sum_valid_b), .sum_ready(sum_ready),
        .sum_sat(sum_sat_b), .count(count_b), .overrun(overrun_b));

    seq_mul_result_acc #(.ACC_W(16), .BATCH(2), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .prod_in(prod_in), .prod_done(prod_done), .clear(clear),
        .sum_out(sum_out_c), .sum_valid(sum_valid_c), .sum_ready(sum_ready),
        .sum_sat(sum_sat_c), .count(count_c), .overrun(overrun_c));

    logic [31:0] o_sum [3];
    logic        o_vld [3];
    logic        o_sat [3];
    logic        o_ovr [3];
    logic [7:0]  o_cnt [3];

    assign o_sum[0] = {16'b0, sum_out_a};
    assign o_sum[1] = {24'b0, sum_out_b};
    assign o_sum[2] = {16'b0, sum_out_c};
    assign o_vld[0] = sum_valid_a;
    assign o_vld[1] = sum_valid_b;
    assign o_vld[2] = sum_valid_c;
    assign o_sat[0] = sum_sat_a;
    assign o_sat[1] = sum_sat_b;
    assign o_sat[2] = sum_sat_c;
    assign o_ovr[0] = overrun_a;
    assign o_ovr[1] = overrun_b;
    assign o_ovr[2] = overrun_c;
    assign o_cnt[0] = count_a;
    assign o_cnt[1] = count_b;
    assign o_cnt[2] = count_c;

    // Reference state per instance, kept as plain integers.
    int     aw [3] = '{16, 8, 16};
    int     bt [3] = '{4, 4, 2};
    longint m_acc [3];
    longint m_sum [3];
    int     m_cnt [3];
    bit     m_bsat [3];
    bit     m_vld [3];
    bit     m_sat [3];
    bit     m_ovr [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            longint maxv;
            longint s;
            bit     was_vld;
            bit     hit;
            maxv = (longint'(1) << aw[k]) - 1;
            if (reset) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_bsat[k] = 0;
                m_sum[k] = 0; m_vld[k] = 0; m_sat[k] = 0; m_ovr[k] = 0;
            end else begin
                was_vld = m_vld[k];
                if (was_vld && sum_ready) m_vld[k] = 0;
                if (clear) begin
                    m_acc[k] = 0; m_cnt[k] = 0; m_bsat[k] = 0;
                end else if (prod_done) begin
                    s   = m_acc[k] + longint'(prod_in);
                    hit = m_bsat[k] || (s > maxv);
                    if (s > maxv) s = maxv;
                    if (m_cnt[k] == bt[k] - 1) begin
                        m_acc[k] = 0; m_cnt[k] = 0; m_bsat[k] = 0;
                        if (!was_vld || sum_ready) begin
                            m_sum[k] = s; m_sat[k] = hit; m_vld[k] = 1;
                        end else begin
                            m_ovr[k] = 1;
                        end
                    end else begin
                        m_acc[k] = s; m_cnt[k] = m_cnt[k] + 1; m_bsat[k] = hit;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse(input logic [7:0] p);
        prod_in   = p;
        prod_done = 1'b1;
        step();
        prod_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            total += 5;
            if (o_sum[k] !== 32'd0) begin bad++; $display("FAIL reset_sum inst=%0d got=%0d exp=0", k, o_sum[k]); end
            if (o_vld[k] !== 1'b0)  begin bad++; $display("FAIL reset_vld inst=%0d got=%b exp=0", k, o_vld[k]); end
            if (o_sat[k] !== 1'b0)  begin bad++; $display("FAIL reset_sat inst=%0d got=%b exp=0", k, o_sat[k]); end
            if (o_ovr[k] !== 1'b0)  begin bad++; $display("FAIL reset_ovr inst=%0d got=%b exp=0", k, o_ovr[k]); end
            if (o_cnt[k] !== 8'd0)  begin bad++; $display("FAIL reset_cnt inst=%0d got=%0d exp=0", k, o_cnt[k]); end
        end
    endtask

    task automatic test_basic_batch();
        logic [7:0] prods [4] = '{8'd15, 8'd14, 8'd225, 8'd1};
        logic [7:0] exp_cnt [4] = '{8'd1, 8'd2, 8'd3, 8'd0};
        do_reset();
        sum_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse(prods[i]);
            total++;
            if (count_a !== exp_cnt[i]) begin bad++; $display("FAIL basic_count i=%0d got=%0d exp=%0d", i, count_a, exp_cnt[i]); end
            total++;
            if (sum_valid_a !== (i == 3)) begin bad++; $display("FAIL basic_vld i=%0d got=%b exp=%b", i, sum_valid_a, (i == 3)); end
            if (i < 3) step();
        end
        total += 4;
        if (sum_out_a !== 16'd255) begin bad++; $display("FAIL basic_sum got=%0d exp=255", sum_out_a); end
        if (sum_sat_a !== 1'b0)    begin bad++; $display("FAIL basic_sat got=%b exp=0", sum_sat_a); end
        if (sum_out_b !== 8'd255)  begin bad++; $display("FAIL basic_sum8_exact got=%0d exp=255", sum_out_b); end
        if (sum_sat_b !== 1'b0)    begin bad++; $display("FAIL basic_sat8_exact got=%b exp=0", sum_sat_b); end
        step();
        total += 2;
        if (sum_valid_a !== 1'b0)  begin bad++; $display("FAIL basic_vld_drop got=%b exp=0", sum_valid_a); end
        if (sum_out_a !== 16'd255) begin bad++; $display("FAIL basic_sum_hold got=%0d exp=255", sum_out_a); end
    endtask

    task automatic test_saturation();
        logic [7:0] p1 [4] = '{8'd225, 8'd225, 8'd4, 8'd1};
        do_reset();
        sum_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin pulse(p1[i]); step(); end
        total += 2;
        if (sum_out_b !== 8'd255) begin bad++; $display("FAIL sat_sum got=%0d exp=255", sum_out_b); end
        if (sum_sat_b !== 1'b1)   begin bad++; $display("FAIL sat_flag got=%b exp=1", sum_sat_b); end
        for (int i = 0; i < 4; i++) begin pulse(8'd1); step(); end
        total += 2;
        if (sum_out_b !== 8'd4) begin bad++; $display("FAIL sat_next_sum got=%0d exp=4", sum_out_b); end
        if (sum_sat_b !== 1'b0) begin bad++; $display("FAIL sat_next_flag got=%b exp=0", sum_sat_b); end
    endtask

    task automatic test_overrun();
        do_reset();
        sum_ready = 1'b0;
        pulse(8'd10); pulse(8'd20);
        total += 2;
        if (sum_out_c !== 16'd30) begin bad++; $display("FAIL ovr_first_sum got=%0d exp=30", sum_out_c); end
        if (sum_valid_c !== 1'b1) begin bad++; $display("FAIL ovr_first_vld got=%b exp=1", sum_valid_c); end
        pulse(8'd5); pulse(8'd6);
        total += 3;
        if (overrun_c !== 1'b1)   begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun_c); end
        if (sum_out_c !== 16'd30) begin bad++; $display("FAIL ovr_sum_hold got=%0d exp=30", sum_out_c); end
        if (sum_valid_c !== 1'b1) begin bad++; $display("FAIL ovr_vld_hold got=%b exp=1", sum_valid_c); end
        sum_ready = 1'b1;
        step();
        total += 2;
        if (sum_valid_c !== 1'b0) begin bad++; $display("FAIL ovr_drain_vld got=%b exp=0", sum_valid_c); end
        if (overrun_c !== 1'b1)   begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun_c); end
    endtask

    task automatic test_load_on_accept();
        do_reset();
        sum_ready = 1'b0;
        pulse(8'd10); pulse(8'd20); pulse(8'd7);
        sum_ready = 1'b1;
        pulse(8'd8);
        sum_ready = 1'b0;
        total += 3;
        if (sum_out_c !== 16'd15) begin bad++; $display("FAIL accload_sum got=%0d exp=15", sum_out_c); end
        if (sum_valid_c !== 1'b1) begin bad++; $display("FAIL accload_vld got=%b exp=1", sum_valid_c); end
        if (overrun_c !== 1'b0)   begin bad++; $display("FAIL accload_ovr got=%b exp=0", overrun_c); end
    endtask

    task automatic test_clear();
        do_reset();
        sum_ready = 1'b1;
        pulse(8'd5); pulse(8'd6);
        total++;
        if (count_a !== 8'd2) begin bad++; $display("FAIL clr_pre_count got=%0d exp=2", count_a); end
        clear = 1'b1;
        pulse(8'd9);
        clear = 1'b0;
        total++;
        if (count_a !== 8'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", count_a); end
        pulse(8'd1); pulse(8'd2); pulse(8'd3); pulse(8'd4);
        total += 2;
        if (sum_out_a !== 16'd10) begin bad++; $display("FAIL clr_sum got=%0d exp=10", sum_out_a); end
        if (sum_valid_a !== 1'b1) begin bad++; $display("FAIL clr_vld got=%b exp=1", sum_valid_a); end
    endtask

    task automatic test_reset_mid_batch();
        do_reset();
        sum_ready = 1'b0;
        pulse(8'd10); pulse(8'd20); pulse(8'd5); pulse(8'd6); pulse(8'd3);
        total++;
        if (overrun_c !== 1'b1) begin bad++; $display("FAIL rmid_pre_ovr got=%b exp=1", overrun_c); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total += 5;
        if (count_a !== 8'd0)     begin bad++; $display("FAIL rmid_count got=%0d exp=0", count_a); end
        if (sum_out_a !== 16'd0)  begin bad++; $display("FAIL rmid_sum got=%0d exp=0", sum_out_a); end
        if (sum_valid_a !== 1'b0) begin bad++; $display("FAIL rmid_vld got=%b exp=0", sum_valid_a); end
        if (overrun_c !== 1'b0)   begin bad++; $display("FAIL rmid_ovr got=%b exp=0", overrun_c); end
        if (sum_out_c !== 16'd0)  begin bad++; $display("FAIL rmid_sum_c got=%0d exp=0", sum_out_c); end
        sum_ready = 1'b1;
        pulse(8'd7);
        total++;
        if (count_a !== 8'd1) begin bad++; $display("FAIL rmid_restart got=%0d exp=1", count_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sum_ready = 1'b1;
        prod_done = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            prod_in = 8'(i);
            step();
            for (int k = 0; k < 3; k++) begin
                total += 2;
                if ({32'b0, o_sum[k]} !== m_sum[k]) begin bad++; $display("FAIL b2b_sum inst=%0d got=%0d exp=%0d", k, o_sum[k], m_sum[k]); end
                if (o_cnt[k] !== 8'(m_cnt[k]))     begin bad++; $display("FAIL b2b_cnt inst=%0d got=%0d exp=%0d", k, o_cnt[k], m_cnt[k]); end
            end
        end
        prod_done = 1'b0;
        total += 2;
        if (sum_out_a !== 16'd10) begin bad++; $display("FAIL b2b_sum_final got=%0d exp=10", sum_out_a); end
        if (sum_valid_a !== 1'b1) begin bad++; $display("FAIL b2b_vld_final got=%b exp=1", sum_valid_a); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            prod_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(150, 255));
            prod_done = ($urandom_range(0, 1) == 1);
            clear     = ($urandom_range(0, 29) == 0);
            sum_ready = ($urandom_range(0, 9) < 4);
            reset     = ($urandom_range(0, 149) == 0);
            step();
            for (int k = 0; k < 3; k++) begin
                total += 5;
                if ({32'b0, o_sum[k]} !== m_sum[k]) begin bad++; $display("FAIL rnd_sum n=%0d inst=%0d got=%0d exp=%0d", n, k, o_sum[k], m_sum[k]); end
                if (o_vld[k] !== m_vld[k])          begin bad++; $display("FAIL rnd_vld n=%0d inst=%0d got=%b exp=%b", n, k, o_vld[k], m_vld[k]); end
                if (o_sat[k] !== m_sat[k])          begin bad++; $display("FAIL rnd_sat n=%0d inst=%0d got=%b exp=%b", n, k, o_sat[k], m_sat[k]); end
                if (o_ovr[k] !== m_ovr[k])          begin bad++; $display("FAIL rnd_ovr n=%0d inst=%0d got=%b exp=%b", n, k, o_ovr[k], m_ovr[k]); end
                if (o_cnt[k] !== 8'(m_cnt[k]))      begin bad++; $display("FAIL rnd_cnt n=%0d inst=%0d got=%0d exp=%0d", n, k, o_cnt[k], m_cnt[k]); end
            end
        end
        prod_done = 1'b0;
        clear     = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        prod_in   = 8'd0;
        prod_done = 1'b0;
        clear     = 1'b0;
        sum_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_bsat[k] = 0;
            m_vld[k] = 0; m_sat[k] = 0; m_ovr[k] = 0;
        end
        test_reset();
        test_basic_batch();
        test_saturation();
        test_overrun();
        test_load_on_accept();
        test_clear();
        test_reset_mid_batch();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mul_result_acc.md
Name: seq_mul_result_acc

Overview:
- Downstream consumer of the sequential 4x4 multiplier.
- Captures each 8-bit product on the multiplier's one-cycle out_done pulse and accumulates BATCH products into a saturating sum.
- Presents the finished sum through a single-entry valid/ready output register.
- Reports saturation and overrun status. Used for dot-product / MAC style sequences built from repeated multiplies.

Parameters:
- ACC_W, 16, accumulator and sum_out width in bits; legal range 8..32.
- BATCH, 4, number of products per sum; legal range 1..255.
- CNT_W, 8, width of the product counter; must hold BATCH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- prod_in  input  8  product from multiplier uo_out; sampled only when prod_done=1.
- prod_done  input  1  one-cycle strobe from multiplier out_done; every high cycle is one product.
- clear  input  1  synchronous batch abort; zeroes acc and cnt only.
- sum_out  output  ACC_W  completed batch sum; stable while sum_valid=1.
- sum_valid  output  1  sum_out holds an unconsumed result.
- sum_ready  input  1  downstream accept; transfer occurs at an edge with sum_valid&sum_ready.
- sum_sat  output  1  saturation occurred within the batch now in sum_out.
- count  output  CNT_W  products accumulated in the current batch.
- overrun  output  1  sticky: a completed batch was discarded because the output slot was full.

Behaviour:
- Reset: synchronous; takes priority over everything else.
  - acc=0, cnt=0, batch_sat=0.
  - sum_out=0, sum_valid=0, sum_sat=0, overrun=0, count=0.
- Internal state: acc (ACC_W), cnt (CNT_W), batch_sat (1). count mirrors cnt.
- Accumulate, on an edge with prod_done=1 and clear=0:
  - s = acc + zero-extended prod_in, computed at ACC_W+1 bits.
  - If s > 2^ACC_W-1: result is 2^ACC_W-1 and the batch is marked saturated (batch_sat | carry).
  - Once saturated, the sum stays at the maximum for the rest of the batch.
- Non-final product (cnt != BATCH-1): acc<=result, cnt<=cnt+1, batch_sat updated.
- Final product (cnt == BATCH-1):
  - acc<=0, cnt<=0, batch_sat<=0.
  - The output slot counts as free if sum_valid=0, or if sum_valid=1 and sum_ready=1 in the same cycle.
  - Slot free: sum_out<=result, sum_sat<=saturation flag including this add, sum_valid<=1.
  - Slot not free: result is discarded, overrun<=1, and sum_out/sum_valid/sum_sat are unchanged.
- Latency: sum_valid rises at the edge that samples the final prod_done; it is visible the next cycle. There are no extra pipeline stages.
- Output handshake:
  - sum_valid&sum_ready at an edge, with no simultaneous load: sum_valid<=0. sum_out and sum_sat hold their values.
  - sum_valid=0 with sum_ready=1: no effect.
  - sum_out and sum_sat never change while sum_valid=1 and the result is not accepted.
- clear=1:
  - acc<=0, cnt<=0, batch_sat<=0.
  - A prod_done in the same cycle is dropped.
  - The output slot and overrun are unaffected; a handshake in the same cycle still completes.
- overrun is cleared only by reset.
- BATCH=1: every product is a final product. sum_out = zero-extended prod_in, with no saturation possible when ACC_W>=8.
- Back-to-back prod_done in consecutive cycles must be accepted without loss. The multiplier never produces this, but the block must not rely on gaps.
- Reset mid-batch: partial acc is lost. The next batch starts at count 0 after reset deasserts.

Test Plan:
- BATCH=4, ACC_W=16, sum_ready=1. Products 15, 14, 225, 1 (3x5, 2x7, 15x15, 1x1), each on a one-cycle prod_done with gaps -> count steps 1,2,3,0; sum_valid pulses one cycle; sum_out=255; sum_sat=0.
- ACC_W=8, BATCH=4. Products 225, 225, 4, 1 -> sum_out=255, sum_sat=1. Then batch 1,1,1,1 -> sum_out=4, sum_sat=0.
- BATCH=2, sum_ready=0.
  - Batch 10+20 -> sum_out=30, sum_valid=1.
  - Batch 5+6 completes while still held -> overrun=1, sum_out stays 30.
  - Assert sum_ready -> sum_valid drops next cycle; overrun stays 1.
- BATCH=2, sum_valid=1 holding 30. Final product of batch 7+8 arrives in the same cycle as sum_ready=1 -> sum_out=15, sum_valid stays 1, overrun=0.
- Clear and reset:
  - After 2 products (count=2), pulse clear together with a prod_done of 9 -> count=0, the 9 is dropped. Next batch 1,2,3,4 -> sum_out=10.
  - Assert reset mid-batch -> all outputs 0.
- BATCH=4, prod_done high for 4 consecutive cycles with products 1,2,3,4 -> sum_out=10 one cycle after the last strobe; no product lost.
